// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store unit and the data memory.
// Latency: n/a (wires only); read data returns one cycle after a request.
// Backpressure: none; one request per cycle, requester must wait for init_done_o.
//
// Signals: access_mem_i/write_mem_i/mem_addr_i/mem_wdata_i come from the LSU;
// mem_rdata_o/init_done_o/err_o/err_addr_o come back from the memory.
// Modports: master = LSU side, slave = memory side.
interface dmem_responder_if;
    logic        access_mem_i;
    logic        write_mem_i;
    logic [63:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [63:0] mem_rdata_o;
    logic        init_done_o;
    logic        err_o;
    logic [63:0] err_addr_o;

    modport master (
        output access_mem_i, write_mem_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, init_done_o, err_o, err_addr_o
    );

    modport slave (
        input  access_mem_i, write_mem_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, init_done_o, err_o, err_addr_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port 64-bit data memory with post-reset zero clear and range checking.
// Latency: 1 cycle read (registered), write visible to the next request.
// Backpressure: none; requests during the clear phase are silently dropped.
//
// Ports: clk, rst_n (async, active-low), bus (dmem_responder_if.slave):
//   access_mem_i/write_mem_i/mem_addr_i/mem_wdata_i request in,
//   mem_rdata_o read data, init_done_o ready flag,
//   err_o sticky out-of-range flag, err_addr_o first faulting address.
module dmem_responder #(
    parameter int          DEPTH      = 1024,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    // 65-bit bounds so BASE_ADDR + DEPTH*8 can never wrap past 2^64.
    localparam logic [64:0] LO_BOUND = {1'b0, BASE_ADDR};
    localparam logic [64:0] HI_BOUND = {1'b0, BASE_ADDR} + 65'(DEPTH) * 65'd8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   clr_cnt_q;

    logic [63:0]     mem [DEPTH];

    logic            in_range;
    logic [AW-1:0]   req_idx;
    logic            ram_we;
    logic [AW-1:0]   ram_idx;
    logic [63:0]     ram_wdata;
    logic            init_done;

    logic [63:0]     rdata_q;
    logic            err_q;
    logic [63:0]     err_addr_q;

    assign in_range = ({1'b0, bus.mem_addr_i} >= LO_BOUND) &&
                      ({1'b0, bus.mem_addr_i} <  HI_BOUND);
    // Word index from the byte offset; the low three address bits drop out.
    assign req_idx  = AW'((bus.mem_addr_i - BASE_ADDR) >> 3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; READY is terminal until the next reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = RST_STATE;
        endcase
    end

    // Output logic: the clear sweep owns the RAM port until READY.
    always_comb begin
        init_done = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = req_idx;
        ram_wdata = bus.mem_wdata_i;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_idx   = clr_cnt_q;
                ram_wdata = 64'd0;
            end
            ST_READY: begin
                init_done = 1'b1;
                ram_we    = bus.access_mem_i && bus.write_mem_i && in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
        end
    end

    // Storage has no reset; contents survive reset and are swept by CLEAR.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= ram_wdata;
        end
    end

    // Read data samples the pre-write word, so a store returns the old value.
    // Dropped or out-of-range requests return zero; idle cycles hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 64'd0;
        end else if (bus.access_mem_i) begin
            if (state_q == ST_READY && in_range) begin
                rdata_q <= mem[req_idx];
            end else begin
                rdata_q <= 64'd0;
            end
        end
    end

    // Only the first faulting address is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= 64'd0;
        end else if (state_q == ST_READY && bus.access_mem_i && !in_range && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= bus.mem_addr_i;
        end
    end

    assign bus.mem_rdata_o = rdata_q;
    assign bus.init_done_o = init_done;
    assign bus.err_o       = err_q;
    assign bus.err_addr_o  = err_addr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with DEPTH=16, BASE_ADDR=0x8000_0000.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// A vector table covers steady-state traffic; reset/clear corners are hand-written.
module tb_dmem_responder;
    logic clk;
    logic rst_n;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH      (16),
        .BASE_ADDR  (64'h0000_0000_8000_0000),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        acc;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [63:0] exp_err_addr;
    } vec_t;

    vec_t vecs[40];
    int   nvec;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic acc, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rdata,
                           input logic exp_err, input logic [63:0] exp_err_addr);
        vecs[nvec].acc          = acc;
        vecs[nvec].wr           = wr;
        vecs[nvec].addr         = addr;
        vecs[nvec].wdata        = wdata;
        vecs[nvec].exp_rdata    = exp_rdata;
        vecs[nvec].exp_err      = exp_err;
        vecs[nvec].exp_err_addr = exp_err_addr;
        nvec++;
    endtask

    task automatic idle_inputs();
        bus.access_mem_i = 1'b0;
        bus.write_mem_i  = 1'b0;
        bus.mem_addr_i   = 64'd0;
        bus.mem_wdata_i  = 64'd0;
    endtask

    // Counts rising edges until init_done_o is seen; gives up after 40.
    task automatic count_init(output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.init_done_o) break;
        end
    endtask

    initial begin
        int edges;
        int rise_edge;
        checks = 0;
        errors = 0;
        nvec   = 0;

        // Steady-state vector table (applied once init is complete).
        for (int i = 0; i < 16; i++)
            add_vec(1, 0, 64'h8000_0000 + 64'(i * 8), 64'd0, 64'd0, 0, 64'd0);
        add_vec(1, 1, 64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 0, 64'd0);
        add_vec(1, 0, 64'h8000_001C, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'd0);
        add_vec(1, 1, 64'h8000_0018, 64'h11, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'd0);
        add_vec(1, 0, 64'h8000_0018, 64'd0, 64'h11, 0, 64'd0);
        add_vec(1, 1, 64'h8000_0018, 64'h22, 64'h11, 0, 64'd0);
        add_vec(1, 0, 64'h8000_0018, 64'd0, 64'h22, 0, 64'd0);
        add_vec(0, 1, 64'h8000_0010, 64'h77, 64'h22, 0, 64'd0);
        add_vec(1, 1, 64'h8000_0080, 64'h99, 64'd0, 1, 64'h8000_0080);
        add_vec(1, 0, 64'h7FFF_FFF8, 64'd0, 64'd0, 1, 64'h8000_0080);
        add_vec(1, 0, 64'h8000_0000, 64'd0, 64'd0, 1, 64'h8000_0080);
        add_vec(1, 0, 64'h8000_0010, 64'd0, 64'd0, 1, 64'h8000_0080);
        add_vec(1, 1, 64'h8000_0078, 64'h33, 64'd0, 1, 64'h8000_0080);
        add_vec(1, 0, 64'h8000_007F, 64'd0, 64'h33, 1, 64'h8000_0080);
        add_vec(1, 0, 64'h8000_0018, 64'd0, 64'h22, 1, 64'h8000_0080);

        // Reset values.
        idle_inputs();
        rst_n = 1'b0;
        #22;
        chk("rst_rdata", bus.mem_rdata_o, 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        chk("rst_err_addr", bus.err_addr_o, 64'd0);
        chk("rst_init_done", 64'(bus.init_done_o), 64'd0);

        // Clear sweep with a write landing at clear cycle 2 (third edge).
        @(negedge clk);
        rst_n = 1'b1;
        rise_edge = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                bus.access_mem_i = 1'b1;
                bus.write_mem_i  = 1'b1;
                bus.mem_addr_i   = 64'h8000_0000;
                bus.mem_wdata_i  = 64'h55;
            end
            @(posedge clk);
            #1;
            if (k == 3) begin
                chk("clear_drop_rdata", bus.mem_rdata_o, 64'd0);
                chk("clear_drop_err", 64'(bus.err_o), 64'd0);
            end
            @(negedge clk);
            idle_inputs();
            if (bus.init_done_o) begin
                rise_edge = k;
                break;
            end
        end
        chk("clear_edges", 64'(rise_edge), 64'd16);

        // Table-driven steady-state traffic.
        for (int i = 0; i < nvec; i++) begin
            bus.access_mem_i = vecs[i].acc;
            bus.write_mem_i  = vecs[i].wr;
            bus.mem_addr_i   = vecs[i].addr;
            bus.mem_wdata_i  = vecs[i].wdata;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rdata", i), bus.mem_rdata_o, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 64'(bus.err_o), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_err_addr", i), bus.err_addr_o, vecs[i].exp_err_addr);
            chk($sformatf("vec%0d_init_done", i), 64'(bus.init_done_o), 64'd1);
            @(negedge clk);
        end
        idle_inputs();

        // Reset during the clear sweep: assert after 7 clear edges.
        rst_n = 1'b0;
        #1;
        chk("rst2_rdata", bus.mem_rdata_o, 64'd0);
        chk("rst2_err", 64'(bus.err_o), 64'd0);
        chk("rst2_init_done", 64'(bus.init_done_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("clear7_init_done", 64'(bus.init_done_o), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst3_rdata", bus.mem_rdata_o, 64'd0);
        chk("rst3_err_addr", bus.err_addr_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_init(edges);
        chk("reclear_edges", 64'(edges), 64'd16);

        // Words written before the reset must be swept back to zero.
        @(negedge clk);
        bus.access_mem_i = 1'b1;
        bus.mem_addr_i   = 64'h8000_0018;
        @(posedge clk);
        #1;
        chk("reclear_word3", bus.mem_rdata_o, 64'd0);
        @(negedge clk);
        bus.mem_addr_i   = 64'h8000_0078;
        @(posedge clk);
        #1;
        chk("reclear_word15", bus.mem_rdata_o, 64'd0);
        chk("reclear_err", 64'(bus.err_o), 64'd0);
        @(negedge clk);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port 64-bit data memory that answers the load/store unit's memory requests (`access_mem` / `write_mem` / `mem_addr` / `mem_wdata` / `mem_rdata`). It sits on the data side of the core, opposite the LSU, and returns read data exactly one cycle after a request. It zero-clears its array after reset, performs address range checking and records the first faulting address for the test harness.

## Interface

- `DEPTH`, 1024: number of 64-bit words; power of two, at least 2.
- `BASE_ADDR`, 64'h0000_0000_8000_0000: byte address of word 0; 8-byte aligned.
- `INIT_CLEAR`, 1: 1 = zero the array after reset; 0 = skip clearing.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `access_mem_i`  in  1  request valid this cycle; covers both read and write.
- `write_mem_i`  in  1  request is a write; meaningful only with `access_mem_i`.
- `mem_addr_i`  in  64  byte address; bits [2:0] ignored.
- `mem_wdata_i`  in  64  full-word write data.
- `mem_rdata_o`  out  64  registered read data.
- `init_done_o`  out  1  high once the array is ready for accesses.
- `err_o`  out  1  sticky out-of-range flag.
- `err_addr_o`  out  64  address of the first out-of-range access.

## Operation

- **Reset values.** `mem_rdata_o` = 0, `err_o` = 0, `err_addr_o` = 0, `init_done_o` = 0 (or 1 when `INIT_CLEAR` = 0).
- **FSM states.** CLEAR, READY.
  - Reset enters CLEAR when `INIT_CLEAR` = 1, otherwise READY.
  - In CLEAR, a clog2(DEPTH)-bit counter starts at 0. Each cycle writes 0 to array[counter] and increments the counter.
  - When the counter = DEPTH-1, that word is written and the FSM moves to READY.
  - READY is terminal until the next reset.
- **Outputs by state.** `init_done_o` = (state == READY).
- **Requests during CLEAR.** Dropped: no array write, no error capture. `mem_rdata_o` loads 0 on the following edge.
- **Range check.** The request is in range iff BASE_ADDR ≤ `mem_addr_i` < BASE_ADDR + DEPTH*8.
  - Compute the range check in 65 bits so the upper bound never wraps.
  - Index = (`mem_addr_i` − BASE_ADDR)[3 +: clog2(DEPTH)].
- **Requests in READY** (each applies when `access_mem_i` = 1):
  - In range: `mem_rdata_o` <= array[index], the pre-write value (read-before-write), for both reads and writes.
  - In range with `write_mem_i` = 1: additionally array[index] <= `mem_wdata_i`.
  - Out of range: no array write, and `mem_rdata_o` <= 0.
  - Out of range with `err_o` = 0: set `err_o` <= 1 and `err_addr_o` <= `mem_addr_i`. Later errors do not update `err_addr_o`.
- **No request** (`access_mem_i` = 0): `mem_rdata_o` holds its value.
- **Partial-width data.** Not handled here. The LSU merges sub-word stores with the prior read data and extracts sub-word loads itself; this block always moves whole words.
- **Asserted reset mid-operation** (during CLEAR or READY):
  - Counter, FSM and outputs return to reset values immediately.
  - Array contents are not reset. They are rewritten by CLEAR, or left unchanged when `INIT_CLEAR` = 0.
- **Storage.** The array is inferred synchronous RAM with a single read/write port, and has no reset.

## Timing

- **Read latency.** 1 cycle: request at edge N, `mem_rdata_o` is valid after edge N and stable until the next request.
- **Write latency.** A write at edge N is visible to a read sampled at edge N+1.
- **Store sequence.** Read A at cycle N, then write A at cycle N+1.
  - `mem_rdata_o` after N = old word.
  - After N+1, `mem_rdata_o` = old word again (read-before-write).
  - The new word is returned by the next read of A.
- **Clear duration.** `init_done_o` rises exactly DEPTH edges after `rst_n` deasserts (with `INIT_CLEAR` = 1).
- **Error flags.** `err_o` / `err_addr_o` update on the same edge as the offending request.
- **Throughput.** One request per cycle, no backpressure and no ready signal. Callers must wait for `init_done_o`.

## Test plan

All tests use `DEPTH` = 16 and `BASE_ADDR` = 0x8000_0000.

- **Clear.** Release reset and count edges -> `init_done_o` rises after 16 edges. Reading all 16 words then returns 0 each; `err_o` stays 0.
- **Write/read.** Write 0xDEADBEEF_CAFEF00D to 0x8000_0018, then read 0x8000_001C next cycle -> `mem_rdata_o` = 0xDEADBEEF_CAFEF00D one cycle later, since bits [2:0] are ignored.
- **Read-before-write.** Word 3 holds 0x11. Read 0x8000_0018, then write 0x22 to it in the next cycle -> `mem_rdata_o` = 0x11 after both edges. A following read returns 0x22.
- **Range error.** Write to 0x8000_0080, then read 0x7FFF_FFF8 -> `err_o` = 1 and `err_addr_o` = 0x8000_0080 (first error only). Both reads return 0, and no array word changes.
- **Reset during CLEAR.** Assert `rst_n` low at clear cycle 7, release -> `init_done_o` rises 16 edges after release. `mem_rdata_o` = 0 during reset.
- **Access during CLEAR.** Write 0x55 to 0x8000_0000 at clear cycle 2 -> write is dropped, `err_o` = 0, and a post-init read of word 0 returns 0.
